vram_port_arbiter: RTL and testbench
====================================

// Module: vram_port_arbiter
// PURPOSE
//  Shares one single-port VRAM between the CPU Avalon-MM master (avmm_1_rw) and the VGA scanout fetcher.
//  Sits between exec_nes / VGA and the VRAM macro. It arbitrates per cycle, registers the memory command,
//  and routes returned read data to the owning requester through a tagged latency pipeline.
//  Video has priority. A starvation counter bounds CPU wait so PPU-side writes always progress.
// PARAMETERS
//  ADDR_W        16  VRAM address width
//  DATA_W         8  VRAM data width
//  RD_LAT         2  cycles from mem_rden to valid mem_q (VRAM macro latency, >=1)
//  CPU_MAX_WAIT   4  consecutive blocked CPU cycles before CPU is forced a grant (>=1)
// PORTS
//  clk               in   1       system clock
//  rst               in   1       asynchronous, active-high reset
//  cpu_address       in   ADDR_W  CPU address, held stable while cpu_waitrequest=1
//  cpu_read          in   1       CPU read request
//  cpu_write         in   1       CPU write request
//  cpu_writedata     in   DATA_W  CPU write data
//  cpu_waitrequest   out  1       combinational; 1 = command not accepted this cycle
//  cpu_readdata      out  DATA_W  CPU read data, registered
//  cpu_readdatavalid out  1       one-cycle pulse qualifying cpu_readdata
//  vid_req           in   1       video read request
//  vid_addr          in   ADDR_W  video read address
//  vid_ack           out  1       combinational; video request accepted this cycle
//  vid_data          out  DATA_W  video read data, registered
//  vid_valid         out  1       one-cycle pulse qualifying vid_data
//  mem_addr          out  ADDR_W  VRAM address, registered
//  mem_wdata         out  DATA_W  VRAM write data, registered
//  mem_wren          out  1       VRAM write enable, registered
//  mem_rden          out  1       VRAM read enable, registered
//  mem_q             in   DATA_W  VRAM read data
// BEHAVIOUR
//  Reset: all registered outputs and the starve counter = 0; in-flight tags cleared. While rst=1,
//   cpu_waitrequest=1 and vid_ack=0. Reads in flight at reset produce no valid pulse, ever.
//  CPU request: cpu_req = cpu_read|cpu_write. If both are high, treat as a write; no readdatavalid.
//  Grant, evaluated combinationally each cycle:
//   - video only -> VID. CPU only -> CPU. Neither -> idle.
//   - both: CPU if starve==CPU_MAX_WAIT, else VID.
//  Counter: starve++ (saturating) on each cycle with cpu_req && !cpu_grant. Clears on CPU grant or !cpu_req.
//  Outputs: cpu_waitrequest = cpu_req & ~cpu_grant. vid_ack = vid_req & vid_grant.
//  Command stage: on the edge after grant, mem_addr/mem_wdata/mem_wren/mem_rden carry the granted command.
//   With no grant: wren=rden=0; addr/wdata hold their last value.
//  Return path: each issued read pushes tag {valid, owner} into a RD_LAT-deep shift register aligned with
//   mem_rden. At the tail, mem_q is registered into cpu_readdata or vid_data and the matching valid pulses.
//   The non-owner data register holds its value.
//  Latency: grant at cycle T -> mem_rden at T+1 -> *_valid at T+2+RD_LAT (T+4 at default).
//  Throughput: one access per cycle, reads and writes freely interleaved. Returns are in issue order, no gaps.
//  Ordering: a CPU write granted at T followed by any read of the same address granted at >=T+1 returns the
//   new data. VRAM read-during-write semantics are therefore never exercised.
//  Requesters may change address/request on any cycle that is not a pending (waitrequest=1) CPU command.
// STRUCTURE
//  Package nes_vram_pkg holds:
//   - owner enum {OWN_CPU, OWN_VID}
//   - rd_tag_t struct {valid, owner}
//   - ADDR_W/DATA_W defaults
//  Sub-module vram_rd_tag_pipe: parameterised RD_LAT delay line of rd_tag_t, async-reset.
//  Arbiter, counter and command/return registers live in the top.
// TESTING
//  1 CPU write 0x2000<=0x5A, then read 0x2000, no video -> waitrequest=0 both; readdatavalid=1 4 cycles after read grant, data 0x5A.
//  2 vid_req held high with addrs 0x0000..0x000F, CPU read pending -> CPU blocked exactly 4 cycles, granted on 5th; video resumes next cycle.
//  3 Interleave video reads and CPU reads back-to-back -> each datum reaches only its owner, in order, one valid per issued read.
//  4 cpu_read=cpu_write=1 at 0x3F00 data 0x11 -> mem_wren=1, mem_rden=0, no readdatavalid; later read returns 0x11.
//  5 rst pulsed with 2 reads in flight -> all outputs 0 immediately; no valid pulse after release.
//  6 CPU write to 0x2400 then video read of 0x2400 next cycle -> vid_data = newly written value.

Source files
------------

// File: rtl/nes_vram_pkg.sv
// nes_vram_pkg: shared types for the VRAM port arbiter.
//   owner_e  : which requester owns an in-flight read (CPU or video)
//   rd_tag_t : per-read tag carried alongside the VRAM read latency
//   ADDR_W_DEF / DATA_W_DEF : default VRAM address / data widths
package nes_vram_pkg;

  localparam int unsigned ADDR_W_DEF = 16;
  localparam int unsigned DATA_W_DEF = 8;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_VID = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
  } rd_tag_t;

endpackage

// File: rtl/vram_rd_tag_pipe.sv
// vram_rd_tag_pipe: DEPTH-stage delay line of read tags, async active-high reset.
//   clk_i  : clock
//   rst_i  : asynchronous active-high reset, clears every stage
//   tag_i  : tag entering the pipe this cycle
//   tag_o  : tag leaving the pipe (tag_i delayed by DEPTH cycles)
module vram_rd_tag_pipe
  import nes_vram_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic    clk_i,
  input  logic    rst_i,
  input  rd_tag_t tag_i,
  output rd_tag_t tag_o
);

  rd_tag_t stage_q [DEPTH];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= tag_i;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vram_port_arbiter.sv
// vram_port_arbiter: shares one single-port VRAM between the CPU Avalon-MM
// master and the video scanout fetcher. Video has priority; a starvation
// counter forces a CPU grant after CPU_MAX_WAIT consecutive blocked cycles.
//   clk, rst                         : clock, async active-high reset
//   cpu_address/read/write/writedata : CPU command (held while waitrequest=1)
//   cpu_waitrequest                  : combinational, command not accepted
//   cpu_readdata/readdatavalid       : registered CPU read return
//   vid_req/vid_addr                 : video read request
//   vid_ack                          : combinational, video request accepted
//   vid_data/vid_valid               : registered video read return
//   mem_addr/wdata/wren/rden         : registered VRAM command
//   mem_q                            : VRAM read data, RD_LAT after mem_rden
module vram_port_arbiter
  import nes_vram_pkg::*;
#(
  parameter int unsigned ADDR_W       = ADDR_W_DEF,
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned RD_LAT       = 2,
  parameter int unsigned CPU_MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [DATA_W-1:0] cpu_writedata,
  output logic              cpu_waitrequest,
  output logic [DATA_W-1:0] cpu_readdata,
  output logic              cpu_readdatavalid,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_ack,
  output logic [DATA_W-1:0] vid_data,
  output logic              vid_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wren,
  output logic              mem_rden,
  input  logic [DATA_W-1:0] mem_q
);

  localparam int unsigned STARVE_W = $clog2(CPU_MAX_WAIT + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(CPU_MAX_WAIT);

  logic                cpu_req, cpu_grant, vid_grant;
  logic [STARVE_W-1:0] starve_q, starve_d;

  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_wren_q, mem_wren_d;
  logic              mem_rden_q, mem_rden_d;
  owner_e            cmd_owner_q, cmd_owner_d;

  logic [DATA_W-1:0] cpu_readdata_q, vid_data_q;
  logic              cpu_rdv_q, vid_valid_q;

  rd_tag_t tag_in, tag_out;

  // Grants are masked by rst so nothing is accepted while in reset.
  assign cpu_req   = cpu_read | cpu_write;
  assign cpu_grant = ~rst & cpu_req & (~vid_req | (starve_q == STARVE_MAX));
  assign vid_grant = ~rst & vid_req & ~cpu_grant;

  assign cpu_waitrequest = rst | (cpu_req & ~cpu_grant);
  assign vid_ack         = vid_req & vid_grant;

  always_comb begin
    starve_d = starve_q;
    if (!cpu_req || cpu_grant) begin
      starve_d = '0;
    end else if (starve_q != STARVE_MAX) begin
      starve_d = starve_q + 1'b1;
    end
  end

  // Read+write together is treated as a write with no read return.
  always_comb begin
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wren_d  = 1'b0;
    mem_rden_d  = 1'b0;
    cmd_owner_d = OWN_CPU;
    if (vid_grant) begin
      mem_addr_d  = vid_addr;
      mem_rden_d  = 1'b1;
      cmd_owner_d = OWN_VID;
    end else if (cpu_grant) begin
      mem_addr_d = cpu_address;
      if (cpu_write) begin
        mem_wdata_d = cpu_writedata;
        mem_wren_d  = 1'b1;
      end else begin
        mem_rden_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wren_q  <= 1'b0;
      mem_rden_q  <= 1'b0;
      cmd_owner_q <= OWN_CPU;
    end else begin
      starve_q    <= starve_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wren_q  <= mem_wren_d;
      mem_rden_q  <= mem_rden_d;
      cmd_owner_q <= cmd_owner_d;
    end
  end

  // Tag enters alongside mem_rden, so it reaches the tail when mem_q is valid.
  assign tag_in = rd_tag_t'{valid: mem_rden_q, owner: cmd_owner_q};

  vram_rd_tag_pipe #(
    .DEPTH (RD_LAT)
  ) u_tag_pipe (
    .clk_i (clk),
    .rst_i (rst),
    .tag_i (tag_in),
    .tag_o (tag_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_readdata_q <= '0;
      vid_data_q     <= '0;
      cpu_rdv_q      <= 1'b0;
      vid_valid_q    <= 1'b0;
    end else begin
      cpu_rdv_q   <= 1'b0;
      vid_valid_q <= 1'b0;
      if (tag_out.valid) begin
        if (tag_out.owner == OWN_CPU) begin
          cpu_readdata_q <= mem_q;
          cpu_rdv_q      <= 1'b1;
        end else begin
          vid_data_q  <= mem_q;
          vid_valid_q <= 1'b1;
        end
      end
    end
  end

  assign mem_addr          = mem_addr_q;
  assign mem_wdata         = mem_wdata_q;
  assign mem_wren          = mem_wren_q;
  assign mem_rden          = mem_rden_q;
  assign cpu_readdata      = cpu_readdata_q;
  assign cpu_readdatavalid = cpu_rdv_q;
  assign vid_data          = vid_data_q;
  assign vid_valid         = vid_valid_q;

endmodule

// File: tb/tb_vram_port_arbiter.sv
// tb_vram_port_arbiter: directed bench for vram_port_arbiter with a behavioural
// 2-cycle VRAM, a shadow memory and an owner-tagged return scoreboard.
module tb_vram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cpu_address;
  logic        cpu_read, cpu_write;
  logic [7:0]  cpu_writedata;
  logic        cpu_waitrequest;
  logic [7:0]  cpu_readdata;
  logic        cpu_readdatavalid;
  logic        vid_req;
  logic [15:0] vid_addr;
  logic        vid_ack;
  logic [7:0]  vid_data;
  logic        vid_valid;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_wren, mem_rden;
  logic [7:0]  mem_q;

  always #5 clk = ~clk;

  vram_port_arbiter #(
    .ADDR_W       (16),
    .DATA_W       (8),
    .RD_LAT       (2),
    .CPU_MAX_WAIT (4)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .cpu_address       (cpu_address),
    .cpu_read          (cpu_read),
    .cpu_write         (cpu_write),
    .cpu_writedata     (cpu_writedata),
    .cpu_waitrequest   (cpu_waitrequest),
    .cpu_readdata      (cpu_readdata),
    .cpu_readdatavalid (cpu_readdatavalid),
    .vid_req           (vid_req),
    .vid_addr          (vid_addr),
    .vid_ack           (vid_ack),
    .vid_data          (vid_data),
    .vid_valid         (vid_valid),
    .mem_addr          (mem_addr),
    .mem_wdata         (mem_wdata),
    .mem_wren          (mem_wren),
    .mem_rden          (mem_rden),
    .mem_q             (mem_q)
  );

  // Behavioural VRAM: data for an address presented with mem_rden appears
  // on mem_q two clock edges later.
  logic [7:0] vram   [0:65535];
  logic [7:0] shadow [0:65535];
  logic [7:0] q0, q1;

  always @(posedge clk) begin
    q1 <= q0;
    q0 <= vram[mem_addr];
    if (mem_wren) vram[mem_addr] <= mem_wdata;
  end
  assign mem_q = q1;

  function automatic logic [7:0] init_val(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  int vectors     = 0;
  int miscompares = 0;
  int valid_seen  = 0;
  logic [8:0] sb [$];   // {owner (0=cpu,1=vid), data}

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ret(input logic own, input logic [7:0] d);
    logic [8:0] e;
    valid_seen++;
    vectors++;
    assert (sb.size() > 0) else begin
      miscompares++;
      $error("FAIL ret_unexpected: observed owner %0d data %0h expected no return", own, d);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      vectors++;
      assert ({own, d} === e) else begin
        miscompares++;
        $error("FAIL ret_data: observed %0h expected %0h", {own, d}, e);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (cpu_readdatavalid) ret(1'b0, cpu_readdata);
      if (vid_valid)         ret(1'b1, vid_data);
    end
  end

  task automatic step(input logic cr, input logic cw, input logic [15:0] ca, input logic [7:0] cd,
                      input logic vr, input logic [15:0] va, output logic cacc, output logic vacc);
    @(negedge clk);
    cpu_read = cr; cpu_write = cw; cpu_address = ca; cpu_writedata = cd;
    vid_req = vr; vid_addr = va;
    #1;
    cacc = (cr | cw) & ~cpu_waitrequest;
    vacc = vid_ack;
    if (cacc) begin
      if (cw) shadow[ca] = cd;
      else    sb.push_back({1'b0, shadow[ca]});
    end
    if (vacc) sb.push_back({1'b1, shadow[va]});
  endtask

  task automatic idle(input int n);
    logic a, b;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, 8'h0, 1'b0, 16'h0, a, b);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic ca, va;
    int lat, vaddr, acc_cyc, blocked_acks, vid_at_grant, vid_after, accepted, v0;
    logic cpu_pend;

    for (int i = 0; i < 65536; i++) begin
      vram[i]   = init_val(16'(i));
      shadow[i] = init_val(16'(i));
    end
    rst = 1'b1;
    cpu_read = 1'b1; cpu_write = 1'b0; cpu_address = 16'h1234; cpu_writedata = 8'h00;
    vid_req = 1'b1; vid_addr = 16'h0000;
    #2;
    check("rst_waitreq", 32'(cpu_waitrequest), 32'd1);
    check("rst_vid_ack", 32'(vid_ack), 32'd0);
    check("rst_regs", 32'({mem_addr, mem_wdata, mem_wren, mem_rden, cpu_readdatavalid, vid_valid}), 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0; cpu_read = 1'b0; vid_req = 1'b0;
    idle(2);

    // 1: write then read back, latency from read grant to readdatavalid
    step(1'b0, 1'b1, 16'h2000, 8'h5A, 1'b0, 16'h0, ca, va);
    check("t1_wr_wait", 32'(cpu_waitrequest), 32'd0);
    step(1'b1, 1'b0, 16'h2000, 8'h00, 1'b0, 16'h0, ca, va);
    check("t1_rd_wait", 32'(cpu_waitrequest), 32'd0);
    lat = 0;
    for (int n = 1; n <= 10 && lat == 0; n++) begin
      step(1'b0, 1'b0, 16'h0, 8'h0, 1'b0, 16'h0, ca, va);
      if (cpu_readdatavalid) lat = n;
    end
    check("t1_latency", 32'(lat), 32'd4);
    check("t1_data", 32'(cpu_readdata), 32'h5A);
    idle(4);

    // 2: continuous video stream with a pending CPU read (starvation bound)
    cpu_pend = 1'b1; vaddr = 0; acc_cyc = -1; blocked_acks = 0; vid_at_grant = 1; vid_after = 0;
    for (int c = 0; c < 40 && (vaddr < 16 || cpu_pend); c++) begin
      step(cpu_pend, 1'b0, 16'h2000, 8'h00, vaddr < 16, 16'(vaddr), ca, va);
      if (c < 4) blocked_acks += int'(va);
      if (acc_cyc >= 0 && c == acc_cyc + 1) vid_after = int'(va);
      if (ca) begin acc_cyc = c; cpu_pend = 1'b0; vid_at_grant = int'(va); end
      if (va) vaddr++;
    end
    check("t2_cpu_grant_cycle", 32'(acc_cyc), 32'd4);
    check("t2_vid_acks_blocked", 32'(blocked_acks), 32'd4);
    check("t2_vid_ack_at_cpu_grant", 32'(vid_at_grant), 32'd0);
    check("t2_vid_resumes", 32'(vid_after), 32'd1);
    idle(8);
    check("t2_drained", 32'(sb.size()), 32'd0);

    // 3: alternating video and CPU reads, back to back
    v0 = valid_seen; accepted = 0;
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) step(1'b0, 1'b0, 16'h0, 8'h0, 1'b1, 16'(16'h0200 + i / 2), ca, va);
      else            step(1'b1, 1'b0, 16'(16'h0100 + i / 2), 8'h0, 1'b0, 16'h0, ca, va);
      accepted += int'(ca) + int'(va);
    end
    idle(8);
    check("t3_accepted", 32'(accepted), 32'd16);
    check("t3_returns", 32'(valid_seen - v0), 32'd16);
    check("t3_drained", 32'(sb.size()), 32'd0);

    // 4: read and write together behave as a write
    step(1'b1, 1'b1, 16'h3F00, 8'h11, 1'b0, 16'h0, ca, va);
    check("t4_accept", 32'(ca), 32'd1);
    step(1'b0, 1'b0, 16'h0, 8'h0, 1'b0, 16'h0, ca, va);
    check("t4_mem_cmd", 32'({mem_wren, mem_rden, mem_addr, mem_wdata}), 32'({1'b1, 1'b0, 16'h3F00, 8'h11}));
    step(1'b1, 1'b0, 16'h3F00, 8'h00, 1'b0, 16'h0, ca, va);
    idle(8);
    check("t4_readback", 32'(cpu_readdata), 32'h11);

    // 6: CPU write followed next cycle by a video read of the same address
    step(1'b0, 1'b1, 16'h2400, 8'hC3, 1'b0, 16'h0, ca, va);
    step(1'b0, 1'b0, 16'h0, 8'h0, 1'b1, 16'h2400, ca, va);
    check("t6_vid_ack", 32'(va), 32'd1);
    idle(8);
    check("t6_vid_data", 32'(vid_data), 32'hC3);

    // 5: reset with two reads in flight
    step(1'b1, 1'b0, 16'h0010, 8'h0, 1'b0, 16'h0, ca, va);
    step(1'b0, 1'b0, 16'h0, 8'h0, 1'b1, 16'h0011, ca, va);
    step(1'b0, 1'b0, 16'h0, 8'h0, 1'b0, 16'h0, ca, va);
    #2;
    cpu_read = 1'b1; vid_req = 1'b1;
    rst = 1'b1;
    #1;
    sb.delete();
    check("t5_regs", 32'({mem_addr, mem_wdata, mem_wren, mem_rden}), 32'd0);
    check("t5_returns", 32'({cpu_readdata, vid_data, cpu_readdatavalid, vid_valid}), 32'd0);
    check("t5_waitreq", 32'(cpu_waitrequest), 32'd1);
    check("t5_vid_ack", 32'(vid_ack), 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0; cpu_read = 1'b0; vid_req = 1'b0;
    v0 = valid_seen;
    idle(10);
    check("t5_no_valid", 32'(valid_seen - v0), 32'd0);
    check("final_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
